// File: rtl/aibcr3_dcc_thm2gry64.sv
// Thermometer-to-grey readback for the DCC delay line: bubble repair, popcount,
// stability filter and a valid/ack handoff of the count in binary and grey.
module aibcr3_dcc_thm2gry64 #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        CLKIN,
  input  logic        RST,
  input  logic [63:0] therm_in,
  input  logic        sample_en,
  input  logic        gry_ack,
  output logic [6:0]  gry_out,
  output logic [6:0]  bin_out,
  output logic        gry_vld,
  output logic        bubble_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] s1_q, s1_d;
  logic        s1_vld_q, s1_vld_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        cnt_vld_q, cnt_vld_d;
  logic [6:0]  prev_q, prev_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [6:0]  bin_q, bin_d;
  logic [6:0]  gry_q, gry_d;
  logic        gry_vld_q, gry_vld_d;
  logic        bubble_q, bubble_d;

  logic [65:0] ext;
  logic [63:0] corr;
  logic [6:0]  cnt_comb;
  logic        raw_bad;
  logic        capture_ok;
  logic        filt_step;
  logic        present;
  logic        ack_clear;

  // Bubble repair: ext carries the implicit 1 below bit0 and 0 above bit63.
  always_comb begin
    ext = {1'b0, s1_q, 1'b1};
    for (int unsigned i = 0; i < 64; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
    end
    cnt_comb = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      cnt_comb = cnt_comb + 7'(corr[i]);
    end
    raw_bad = |(s1_q[63:1] & ~s1_q[62:0]);
  end

  always_comb begin
    capture_ok = (state_q != HOLD);
    filt_step  = cnt_vld_q && capture_ok;

    s1_d      = s1_q;
    s1_vld_d  = sample_en && capture_ok;
    if (sample_en && capture_ok) begin
      s1_d = therm_in;
    end

    cnt_d     = s1_vld_q ? cnt_comb : cnt_q;
    cnt_vld_d = s1_vld_q && capture_ok;

    prev_d = prev_q;
    mcnt_d = mcnt_q;
    if (filt_step) begin
      if ((mcnt_q == 4'd0) || (cnt_q != prev_q)) begin
        prev_d = cnt_q;
        mcnt_d = 4'd1;
      end else if (mcnt_q != 4'd15) begin
        mcnt_d = mcnt_q + 4'd1;
      end
    end

    state_d   = state_q;
    present   = 1'b0;
    ack_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_vld_q) begin
          state_d = FILTER;
          if (mcnt_d == 4'(STABLE_CNT)) present = 1'b1;
        end
      end
      FILTER: begin
        if (filt_step && (mcnt_d == 4'(STABLE_CNT))) present = 1'b1;
      end
      HOLD: begin
        if (gry_ack) begin
          state_d   = IDLE;
          ack_clear = 1'b1;
          mcnt_d    = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    bin_d     = bin_q;
    gry_d     = gry_q;
    gry_vld_d = gry_vld_q;
    if (present) begin
      state_d   = HOLD;
      bin_d     = prev_d;
      gry_d     = prev_d ^ (prev_d >> 1);
      gry_vld_d = 1'b1;
    end
    if (ack_clear) gry_vld_d = 1'b0;

    // Set wins over clear so a bubble arriving with the ack is kept for the next result.
    bubble_d = (ack_clear ? 1'b0 : bubble_q) | (s1_vld_q & raw_bad);
  end

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      cnt_q     <= '0;
      cnt_vld_q <= 1'b0;
      prev_q    <= '0;
      mcnt_q    <= '0;
      bin_q     <= '0;
      gry_q     <= '0;
      gry_vld_q <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      cnt_q     <= cnt_d;
      cnt_vld_q <= cnt_vld_d;
      prev_q    <= prev_d;
      mcnt_q    <= mcnt_d;
      bin_q     <= bin_d;
      gry_q     <= gry_d;
      gry_vld_q <= gry_vld_d;
      bubble_q  <= bubble_d;
    end
  end

  assign gry_out    = gry_q;
  assign bin_out    = bin_q;
  assign gry_vld    = gry_vld_q;
  assign bubble_err = bubble_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aibcr3_dcc_thm2gry64.sv
// Directed bench: default STABLE_CNT=4 instance plus a STABLE_CNT=1 instance for the
// single-count boundary; inputs change 1ns after each rising edge and are checked there.
module tb_aibcr3_dcc_thm2gry64;

  logic        clk;
  logic        rst;
  logic [63:0] therm_in;
  logic        sample_en;
  logic        gry_ack;
  logic [6:0]  gry_out, bin_out;
  logic        gry_vld, bubble_err, busy;
  logic [6:0]  gry_out1, bin_out1;
  logic        gry_vld1, bubble_err1, busy1;

  int errors = 0;
  int checks = 0;

  aibcr3_dcc_thm2gry64 #(.STABLE_CNT(4)) dut (
    .CLKIN(clk), .RST(rst), .therm_in(therm_in), .sample_en(sample_en),
    .gry_ack(gry_ack), .gry_out(gry_out), .bin_out(bin_out), .gry_vld(gry_vld),
    .bubble_err(bubble_err), .busy(busy)
  );

  aibcr3_dcc_thm2gry64 #(.STABLE_CNT(1)) dut1 (
    .CLKIN(clk), .RST(rst), .therm_in(therm_in), .sample_en(sample_en),
    .gry_ack(gry_ack), .gry_out(gry_out1), .bin_out(bin_out1), .gry_vld(gry_vld1),
    .bubble_err(bubble_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until gry_vld rises; n is the number of edges taken (bounded).
  task automatic wait_vld(output int n);
    n = 0;
    while (!gry_vld && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Drop sampling, spend one cycle in HOLD, then acknowledge.
  task automatic accept(input string tag, input logic [6:0] bin_exp);
    sample_en = 1'b0;
    tick();
    chk({tag, "_hold_bin"}, bin_out, bin_exp);
    chk({tag, "_hold_vld"}, gry_vld, 1);
    gry_ack = 1'b1;
    tick();
    gry_ack = 1'b0;
    chk({tag, "_ack_vld"}, gry_vld, 0);
    chk({tag, "_ack_busy"}, busy, 0);
    chk({tag, "_ack_bubble"}, bubble_err, 0);
    chk({tag, "_ack_keep_bin"}, bin_out, bin_exp);
  endtask

  int n;
  int v1_cycle;
  int hi_cnt;

  initial begin
    rst = 1'b1; therm_in = '0; sample_en = 1'b0; gry_ack = 1'b0;
    tick(); tick();
    chk("rst_vld", gry_vld, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_gry", gry_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bubble", bubble_err, 0);
    rst = 1'b0;

    // Test 1: all zeros, cycle 0 is now; both instances observed.
    therm_in = 64'h0; sample_en = 1'b1;
    n = 0; v1_cycle = -1;
    while (!gry_vld && n < 40) begin
      tick();
      n++;
      if (gry_vld1 && v1_cycle < 0) v1_cycle = n;
    end
    chk("t1_latency", n, 6);
    chk("t1_bin", bin_out, 7'h00);
    chk("t1_gry", gry_out, 7'h00);
    chk("t1_bubble", bubble_err, 0);
    chk("t1_busy", busy, 1);
    chk("sc1_latency", v1_cycle, 3);
    chk("sc1_bin", bin_out1, 7'h00);
    accept("t1", 7'h00);

    // ack with nothing pending is ignored
    gry_ack = 1'b1;
    tick();
    gry_ack = 1'b0;
    chk("idle_ack_vld", gry_vld, 0);
    chk("idle_ack_busy", busy, 0);

    // Test 2: 16 ones
    therm_in = 64'h0000_0000_0000_FFFF; sample_en = 1'b1;
    wait_vld(n);
    chk("t2_latency", n, 6);
    chk("t2_bin", bin_out, 7'h10);
    chk("t2_gry", gry_out, 7'h18);
    therm_in = 64'h0;
    accept("t2", 7'h10);
    chk("t2_frozen_gry", gry_out, 7'h18);

    // Test 3: all ones, top of range
    therm_in = '1; sample_en = 1'b1;
    wait_vld(n);
    chk("t3_latency", n, 6);
    chk("t3_bin", bin_out, 7'h40);
    chk("t3_gry", gry_out, 7'h60);
    accept("t3", 7'h40);

    // Test 4: bubble at bit2 is repaired and flagged
    therm_in = 64'h0000_0000_0000_00FB; sample_en = 1'b1;
    tick(); tick();
    chk("t4_bubble_early", bubble_err, 1);
    wait_vld(n);
    chk("t4_latency", n, 4);
    chk("t4_bin", bin_out, 7'h08);
    chk("t4_gry", gry_out, 7'h0C);
    chk("t4_bubble", bubble_err, 1);
    accept("t4", 7'h08);

    // Test 5: alternating counts never settle
    hi_cnt = 0;
    sample_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      therm_in = (i % 2 == 0) ? 64'hFF : 64'hF;
      tick();
      if (gry_vld) hi_cnt++;
    end
    chk("t5_alt_vld", hi_cnt, 0);
    chk("t5_alt_busy", busy, 1);
    therm_in = 64'hFF;
    wait_vld(n);
    chk("t5_latency", n, 6);
    chk("t5_bin", bin_out, 7'h08);
    chk("t5_gry", gry_out, 7'h0C);

    // Test 6: reset while a result is pending
    gry_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vld", gry_vld, 0);
    chk("t6_bin", bin_out, 0);
    chk("t6_gry", gry_out, 0);
    chk("t6_busy", busy, 0);
    therm_in = 64'h0000_0000_0000_FFFF; sample_en = 1'b1;
    wait_vld(n);
    chk("t6_latency", n, 6);
    chk("t6_bin_after", bin_out, 7'h10);
    chk("t6_gry_after", gry_out, 7'h18);
    accept("t6", 7'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
